// File: rtl/writeback.sv
// Writeback stage: load alignment/extension, 32x32 register file with write bypass,
// load-wait FSM with timeout, retired-instruction counter and sticky exception flag.
module writeback #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             wb_valid,
    input  logic [31:0]      wb_result,
    input  logic             wb_alu2reg,
    input  logic             wb_mem2reg,
    input  logic [4:0]       wb_dst_sel,
    input  logic [1:0]       wb_raddr,
    input  logic [2:0]       wb_alu_op,
    input  logic [31:0]      dmem_rdata,
    input  logic             dmem_rvalid,
    input  logic [4:0]       rs1_sel,
    input  logic [4:0]       rs2_sel,
    output logic [31:0]      rs1_data,
    output logic [31:0]      rs2_data,
    output logic             rf_we,
    output logic [4:0]       rf_dst,
    output logic [31:0]      rf_wdata,
    output logic             wb_stall,
    output logic [CNT_W-1:0] instret,
    output logic             exception
);

    // state  | meaning
    // S_IDLE | accepting instructions from execute
    // S_WAIT | load issued, waiting for dmem_rvalid; wb_* inputs ignored
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           r_state;
    logic [TW-1:0]    r_wait_cnt;
    logic [4:0]       r_dst;
    logic [2:0]       r_op;
    logic [1:0]       r_off;
    logic             r_exception;
    logic [CNT_W-1:0] r_instret;
    logic [31:0]      r_regs [32];

    logic             w_in_wait;
    logic             w_issue;
    logic             w_load_fault;
    logic             w_go_wait;
    logic             w_timeout;
    logic             w_wait_done;
    logic             w_retire;
    logic             w_is_load;
    logic             w_writes;
    logic [2:0]       w_op;
    logic [1:0]       w_off;

    function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            3'b000, 3'b100: f_misaligned = 1'b0;
            3'b001, 3'b101: f_misaligned = off[0];
            3'b010:         f_misaligned = (off != 2'b00);
            default:        f_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = off[1] ? data[31:16] : data[15:0];
        case (op)
            3'b000:  f_load = {{24{b[7]}}, b};
            3'b001:  f_load = {{16{h[15]}}, h};
            3'b100:  f_load = {24'd0, b};
            3'b101:  f_load = {16'd0, h};
            default: f_load = data;
        endcase
    endfunction

    // Misaligned/illegal loads fault at issue and never enter WAIT.
    assign w_in_wait    = (r_state == S_WAIT);
    assign w_issue      = !w_in_wait && wb_valid && !r_exception;
    assign w_load_fault = w_issue && wb_mem2reg && f_misaligned(wb_alu_op, wb_raddr);
    assign w_go_wait    = w_issue && wb_mem2reg && !w_load_fault && !dmem_rvalid;
    assign w_timeout    = w_in_wait && !dmem_rvalid && (r_wait_cnt == '0);
    assign w_wait_done  = w_in_wait && dmem_rvalid;
    assign w_retire     = (w_issue && !w_load_fault && !w_go_wait) || w_wait_done;

    assign w_is_load = w_in_wait ? 1'b1 : wb_mem2reg;
    assign w_writes  = w_in_wait ? 1'b1 : (wb_alu2reg | wb_mem2reg);
    assign w_op      = w_in_wait ? r_op  : wb_alu_op;
    assign w_off     = w_in_wait ? r_off : wb_raddr;

    assign rf_dst    = w_in_wait ? r_dst : wb_dst_sel;
    assign rf_wdata  = w_is_load ? f_load(w_op, w_off, dmem_rdata) : wb_result;
    assign rf_we     = w_retire && w_writes && (rf_dst != 5'd0);
    assign wb_stall  = w_go_wait || (w_in_wait && !dmem_rvalid && !w_timeout);

    assign instret   = r_instret;
    assign exception = r_exception;

    always_comb begin
        rs1_data = r_regs[rs1_sel];
        if (rf_we && (rs1_sel == rf_dst)) rs1_data = rf_wdata;
        if (rs1_sel == 5'd0) rs1_data = '0;
    end

    always_comb begin
        rs2_data = r_regs[rs2_sel];
        if (rf_we && (rs2_sel == rf_dst)) rs2_data = rf_wdata;
        if (rs2_sel == 5'd0) rs2_data = '0;
    end

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_dst       <= '0;
            r_op        <= '0;
            r_off       <= '0;
            r_exception <= 1'b0;
            r_instret   <= '0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            if (rf_we) r_regs[rf_dst] <= rf_wdata;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
            if (w_load_fault || w_timeout) r_exception <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_go_wait) begin
                        r_state    <= S_WAIT;
                        r_dst      <= wb_dst_sel;
                        r_op       <= wb_alu_op;
                        r_off      <= wb_raddr;
                        r_wait_cnt <= TW'(TIMEOUT - 1);
                    end
                end
                S_WAIT: begin
                    // Down-counter reaching zero on the TIMEOUT-th WAIT cycle is the timeout.
                    if (dmem_rvalid || w_timeout) r_state <= S_IDLE;
                    else r_wait_cnt <= r_wait_cnt - TW'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max cycles spent in WAIT before a load-timeout exception.
REQ-002 SHALL have parameter CNT_W, default 64, meaning width of retired-instruction counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port resetb  input  1  reset, asynchronous and active-high (port name kept per codebase; asserted = 1).
REQ-005 SHALL have port wb_valid  input  1  an instruction is present from execute this cycle.
REQ-006 SHALL have port wb_result  input  32  ALU result from execute.
REQ-007 SHALL have port wb_alu2reg  input  1  write wb_result to rd.
REQ-008 SHALL have port wb_mem2reg  input  1  write load data to rd.
REQ-009 SHALL have port wb_dst_sel  input  5  destination register index.
REQ-010 SHALL have port wb_raddr  input  2  load byte offset (address[1:0]).
REQ-011 SHALL have port wb_alu_op  input  3  load funct3.
REQ-012 SHALL have port dmem_rdata  input  32  data-memory read word.
REQ-013 SHALL have port dmem_rvalid  input  1  dmem_rdata valid this cycle.
REQ-014 SHALL have ports rs1_sel, rs2_sel  input  5 each  register read indices from decode.
REQ-015 SHALL have ports rs1_data, rs2_data  output  32 each  register read data.
REQ-016 SHALL have ports rf_we  output  1, rf_dst  output  5, rf_wdata  output  32  current-cycle register write.
REQ-017 SHALL have port wb_stall  output  1  freeze upstream stages.
REQ-018 SHALL have port instret  output  CNT_W  retired-instruction count.
REQ-019 SHALL have port exception  output  1  sticky fault flag.

Function
REQ-020 SHALL extract load data: 000 LB sign-extended byte at offset; 001 LH sign-extended half at offset[1]; 010 LW; 100 LBU zero-extended; 101 LHU zero-extended.
REQ-021 SHALL flag exception on load funct3 011/110/111, LH/LHU with offset[0]=1, or LW with offset!=0; faulting instruction writes nothing and does not retire.
REQ-022 SHALL select rf_wdata = load data when mem2reg, else wb_result.
REQ-023 SHALL assert rf_we only when a valid instruction completes with alu2reg|mem2reg, rf_dst!=0, no exception, not stalling.
REQ-024 SHALL hold 32x32 register file, written at posedge when rf_we; x0 reads 0 always.
REQ-025 SHALL return reads combinationally with bypass: rsN_sel==rf_dst and rf_we gives rf_wdata same cycle.
REQ-026 SHALL run FSM IDLE/WAIT: IDLE + valid mem2reg + !dmem_rvalid -> WAIT, capture dst/op/offset; WAIT + dmem_rvalid -> write captured, retire, IDLE.
REQ-027 SHALL assert wb_stall combinationally in the IDLE->WAIT cycle and every WAIT cycle up to, not including, completion cycle.
REQ-028 SHALL ignore wb_* inputs while in WAIT.
REQ-029 SHALL count WAIT cycles; at TIMEOUT with no dmem_rvalid, set exception, drop wb_stall, return IDLE, no write.
REQ-030 SHALL increment instret by 1 per retired instruction (incl. stores/branches with no rd), wrapping at 2^CNT_W.
REQ-031 SHALL keep exception set once raised; after it, no further writes or retirements until reset.

Reset
REQ-032 SHALL on resetb=1 asynchronously clear all registers, instret, exception, timeout counter, state to IDLE; rf_we=0, wb_stall=0.
REQ-033 SHALL abandon an in-flight WAIT on reset with no write.

Verification
REQ-034 SHALL cover: ALU write wb_result=0x1234, dst=5 -> rf_we=1, x5=0x1234, instret+1; same with dst=0 -> rf_we=0, x0=0, instret+1.
REQ-035 SHALL cover: dmem_rdata=0x80FF7F01, LB offset 3 -> 0xFFFFFF80; LBU offset 1 -> 0x0000007F; LH offset 2 -> 0xFFFF80FF.
REQ-036 SHALL cover: LW offset 1 -> exception=1 next cycle, no write, sticky until reset.
REQ-037 SHALL cover: load dmem_rvalid low 3 cycles -> wb_stall high 3 cycles, one write on 4th cycle; low TIMEOUT cycles -> exception.
REQ-038 SHALL cover: write x7=0xA5 with rs1_sel=7 same cycle -> rs1_data=0xA5 via bypass.
REQ-039 SHALL cover: resetb asserted mid-WAIT -> IDLE, wb_stall=0, instret=0, all registers 0.
